// File: rtl/lcd_text_sequencer.sv
// Two-row text frame buffer that repaints an HD44780 panel through the driver's
// trigger/busy handshake whenever the image is dirty or a refresh is requested.
module lcd_text_sequencer #(
    parameter int COLS = 16,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          refresh,
    input  logic          drv_busy,
    output logic          drv_trg,
    output logic          drv_rs,
    output logic [7:0]    drv_data,
    output logic          active,
    output logic          done
);

    localparam int DEPTH  = 2 * COLS;
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NITEMS = DEPTH + 2;
    localparam int KW     = $clog2(NITEMS);

    localparam logic [KW-1:0] K_ROW1  = KW'(COLS + 1);
    localparam logic [KW-1:0] K_LAST  = KW'(NITEMS - 1);
    localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_WAITB = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          dirty_q, dirty_d;
    logic          trg_q, trg_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic [7:0]    mem_q [DEPTH];

    logic          wr_ok_s;
    logic          start_s;
    logic [KW-1:0] item_k_s;
    logic [IW-1:0] item_idx_s;
    logic          item_rs_s;
    logic [7:0]    item_data_s;

    assign wr_ok_s = wr_en && ({1'b0, wr_addr} < DEPTH_A);
    assign start_s = (state_q == S_IDLE) && (dirty_q || refresh) && !drv_busy;

    // Frame buffer: blanked on reset, host writes land immediately.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h20;
            end
        end else if (wr_ok_s) begin
            mem_q[IW'(wr_addr)] <= wr_data;
        end
    end

    // Byte/rs of the item about to be loaded: item 0 from IDLE, else k+1.
    always_comb begin
        item_k_s    = (state_q == S_IDLE) ? {KW{1'b0}} : (k_q + KW'(1));
        item_idx_s  = {IW{1'b0}};
        item_rs_s   = 1'b0;
        item_data_s = 8'h80;
        if (item_k_s == {KW{1'b0}}) begin
            item_rs_s   = 1'b0;
            item_data_s = 8'h80;
        end else if (item_k_s < K_ROW1) begin
            item_idx_s  = IW'(item_k_s - KW'(1));
            item_rs_s   = 1'b1;
            item_data_s = mem_q[item_idx_s];
        end else if (item_k_s == K_ROW1) begin
            item_rs_s   = 1'b0;
            item_data_s = 8'hC0;
        end else begin
            item_idx_s  = IW'(item_k_s - KW'(2));
            item_rs_s   = 1'b1;
            item_data_s = mem_q[item_idx_s];
        end
    end

    // Dirty flag: a write or refresh beats the clear of a starting repaint,
    // except a refresh that is itself the reason the repaint starts.
    always_comb begin
        dirty_d = dirty_q;
        if (wr_ok_s || (refresh && !(start_s && !dirty_q))) begin
            dirty_d = 1'b1;
        end else if (start_s) begin
            dirty_d = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Repaint FSM: IDLE -> (ISSUE -> HOLD -> WAITB) per item -> IDLE.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        trg_d    = 1'b0;
        rs_d     = rs_q;
        data_d   = data_q;
        active_d = active_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    k_d      = {KW{1'b0}};
                    active_d = 1'b1;
                    trg_d    = 1'b1;
                    rs_d     = item_rs_s;
                    data_d   = item_data_s;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_HOLD;
            S_HOLD:  state_d = S_WAITB;
            S_WAITB: begin
                if (drv_busy) begin
                    state_d = S_WAITB;
                end else if (k_q == K_LAST) begin
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    k_d     = item_k_s;
                    trg_d   = 1'b1;
                    rs_d    = item_rs_s;
                    data_d  = item_data_s;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            k_q      <= {KW{1'b0}};
            dirty_q  <= 1'b1;
            trg_q    <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            dirty_q  <= dirty_d;
            trg_q    <= trg_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign drv_trg  = trg_q;
    assign drv_rs   = rs_q;
    assign drv_data = data_q;
    assign active   = active_q;
    assign done     = done_q;

endmodule
